// File: rtl/neo_sdram_pkg.sv
// Shared definitions for the SDRAM burst-read fetch path.
//   LINE_WORDS_DEF : default number of 32-bit words per cache line
//   BURST_LEN      : default burst length in halfwords (2 x LINE_WORDS_DEF)
//   fetch_state_e  : fetch FSM states
//   burst_len_of() : burst length in halfwords for a given line size
package neo_sdram_pkg;

  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned BURST_LEN      = 2 * LINE_WORDS_DEF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFill,
    StResp
  } fetch_state_e;

  function automatic logic [10:0] burst_len_of(input int unsigned words);
    return 11'(2 * words);
  endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// Two-line data store for the burst fetcher: 2 x LINE_WORDS x 32 bits.
//   clk_i                      : clock
//   rst_i                      : synchronous active-high reset (read register only)
//   we_i, wline_i, wword_i,
//   wdata_i                    : synchronous write port
//   re_i, rline_i, rword_i     : read port; data appears on rdata_o after the edge
//   rdata_o                    : registered read data, holds until the next read
module burst_line_buffer #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          we_i,
  input  logic                          wline_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
  input  logic [31:0]                   wdata_i,
  input  logic                          re_i,
  input  logic                          rline_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
  output logic [31:0]                   rdata_o
);

  localparam int unsigned Depth = 2 * LINE_WORDS;

  // Storage is left unreset so it can map onto MLAB/distributed RAM.
  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wline_i, wword_i}] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[{rline_i, rword_i}];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_burst_fetch.sv
// Core-side burst-read initiator with a two-line, round-robin replaced buffer.
//   controller_clk, reset       : clock and synchronous active-high reset
//   core_rd/core_addr           : single-cycle read request, byte address
//   flush                       : invalidate both lines
//   core_q/core_ack/core_busy   : read data, ack pulse, busy while a request is open
//   fill_err                    : sticky, set when a burst ends short
//   burst_rd/addr/len/32bit     : burst request to the SDRAM controller
//   burst_data/_valid/_done     : returned beat stream
module sdram_burst_fetch
  import neo_sdram_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned ADDR_W     = 26
) (
  input  logic              controller_clk,
  input  logic              reset,
  input  logic              core_rd,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              flush,
  output logic [31:0]       core_q,
  output logic              core_ack,
  output logic              core_busy,
  output logic              fill_err,
  output logic              burst_rd,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [10:0]       burst_len,
  output logic              burst_32bit,
  input  logic [31:0]       burst_data,
  input  logic              burst_data_valid,
  input  logic              burst_data_done
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned TagW = ADDR_W - OffW - 2;
  localparam int unsigned BcW  = OffW + 1;
  localparam logic [BcW-1:0] FullCnt = BcW'(LINE_WORDS);

  fetch_state_e state_q, state_d;
  logic [OffW-1:0]         off_q, off_d;
  logic [TagW-1:0]         tag_q, tag_d;
  logic                    sel_q, sel_d;
  logic                    rr_q, rr_d;
  logic [1:0]              valid_q, valid_d;
  logic [1:0][TagW-1:0]    tags_q, tags_d;
  logic [BcW-1:0]          bc_q, bc_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    fill_err_q, fill_err_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic                    burst_rd_q, burst_rd_d;
  logic [ADDR_W-1:0]       burst_addr_q, burst_addr_d;

  logic [OffW-1:0] off_in;
  logic [TagW-1:0] tag_in;
  logic            beat_take;
  logic [BcW-1:0]  bc_inc;
  logic [1:0]      vmask;
  logic            hit0, hit1;
  logic            unused_addr_lsb;

  assign off_in          = core_addr[OffW+1:2];
  assign tag_in          = core_addr[ADDR_W-1:OffW+2];
  assign unused_addr_lsb = ^core_addr[1:0];

  // Beats past the end of the line are counted out but never stored.
  assign beat_take = (state_q == StFill) && burst_data_valid && (bc_q < FullCnt);
  assign bc_inc    = bc_q + BcW'(beat_take);

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    tag_d        = tag_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    valid_d      = valid_q;
    tags_d       = tags_q;
    bc_d         = bc_q;
    flush_pend_d = flush_pend_q;
    fill_err_d   = fill_err_q;
    busy_d       = busy_q;
    ack_d        = 1'b0;
    burst_rd_d   = 1'b0;
    burst_addr_d = burst_addr_q;
    vmask        = valid_q;
    hit0         = 1'b0;
    hit1         = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A flush (live or deferred) takes effect before the lookup.
        if (flush || flush_pend_q) begin
          vmask = 2'b00;
        end
        valid_d      = vmask;
        flush_pend_d = 1'b0;
        hit0 = vmask[0] && (tags_q[0] == tag_in);
        hit1 = vmask[1] && (tags_q[1] == tag_in);
        if (core_rd && !busy_q) begin
          off_d  = off_in;
          tag_d  = tag_in;
          busy_d = 1'b1;
          if (hit0 || hit1) begin
            sel_d   = !hit0;
            state_d = StResp;
          end else begin
            sel_d          = rr_q;
            valid_d[rr_q]  = 1'b0;
            rr_d           = !rr_q;
            state_d        = StIssue;
          end
        end else if (ack_q) begin
          busy_d = 1'b0;
        end
      end
      StIssue: begin
        flush_pend_d = flush_pend_q || flush;
        burst_rd_d   = 1'b1;
        burst_addr_d = {tag_q, {(OffW + 2){1'b0}}};
        bc_d         = '0;
        state_d      = StFill;
      end
      StFill: begin
        flush_pend_d = flush_pend_q || flush;
        bc_d         = bc_inc;
        if (burst_data_done) begin
          if ((bc_inc == FullCnt) && !(flush_pend_q || flush)) begin
            valid_d[sel_q] = 1'b1;
            tags_d[sel_q]  = tag_q;
          end
          if (bc_inc < FullCnt) begin
            fill_err_d = 1'b1;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        flush_pend_d = flush_pend_q || flush;
        ack_d        = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge controller_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      off_q        <= '0;
      tag_q        <= '0;
      sel_q        <= 1'b0;
      rr_q         <= 1'b0;
      valid_q      <= 2'b00;
      tags_q       <= '0;
      bc_q         <= '0;
      flush_pend_q <= 1'b0;
      fill_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      burst_rd_q   <= 1'b0;
      burst_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      tag_q        <= tag_d;
      sel_q        <= sel_d;
      rr_q         <= rr_d;
      valid_q      <= valid_d;
      tags_q       <= tags_d;
      bc_q         <= bc_d;
      flush_pend_q <= flush_pend_d;
      fill_err_q   <= fill_err_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      burst_rd_q   <= burst_rd_d;
      burst_addr_q <= burst_addr_d;
    end
  end

  // Read is launched in StResp so the registered word lines up with core_ack.
  burst_line_buffer #(
    .LINE_WORDS(LINE_WORDS)
  ) u_buf (
    .clk_i  (controller_clk),
    .rst_i  (reset),
    .we_i   (beat_take),
    .wline_i(sel_q),
    .wword_i(bc_q[OffW-1:0]),
    .wdata_i(burst_data),
    .re_i   (state_q == StResp),
    .rline_i(sel_q),
    .rword_i(off_q),
    .rdata_o(core_q)
  );

  assign core_ack    = ack_q;
  assign core_busy   = busy_q;
  assign fill_err    = fill_err_q;
  assign burst_rd    = burst_rd_q;
  assign burst_addr  = burst_addr_q;
  assign burst_len   = burst_len_of(LINE_WORDS);
  assign burst_32bit = 1'b1;

endmodule

// File: tb/tb_sdram_burst_fetch.sv
module tb_sdram_burst_fetch;

  localparam int unsigned LW = 8;
  localparam int unsigned AW = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_rd;
  logic [AW-1:0] core_addr;
  logic          flush;
  logic [31:0]   core_q;
  logic          core_ack;
  logic          core_busy;
  logic          fill_err;
  logic          burst_rd;
  logic [AW-1:0] burst_addr;
  logic [10:0]   burst_len;
  logic          burst_32bit;
  logic [31:0]   burst_data;
  logic          burst_data_valid;
  logic          burst_data_done;

  int total = 0;
  int bad = 0;
  int burst_cnt = 0;
  int ack_cnt = 0;

  sdram_burst_fetch #(
    .LINE_WORDS(LW),
    .ADDR_W    (AW)
  ) dut (
    .controller_clk  (clk),
    .reset           (reset),
    .core_rd         (core_rd),
    .core_addr       (core_addr),
    .flush           (flush),
    .core_q          (core_q),
    .core_ack        (core_ack),
    .core_busy       (core_busy),
    .fill_err        (fill_err),
    .burst_rd        (burst_rd),
    .burst_addr      (burst_addr),
    .burst_len       (burst_len),
    .burst_32bit     (burst_32bit),
    .burst_data      (burst_data),
    .burst_data_valid(burst_data_valid),
    .burst_data_done (burst_data_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (burst_rd === 1'b1) burst_cnt++;
    if (core_ack === 1'b1) ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rd(input logic [AW-1:0] a);
    core_addr = a;
    core_rd   = 1'b1;
    tick();
    core_rd   = 1'b0;
  endtask

  // Controller model: wait for burst_rd, send nbeats words base+i, then done.
  task automatic serve(input int nbeats, input logic [31:0] base, input int flush_at,
                       output bit seen, output logic [AW-1:0] addr);
    seen = 1'b0;
    addr = '0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (burst_rd === 1'b1) begin
        seen = 1'b1;
        addr = burst_addr;
      end else begin
        tick();
      end
    end
    if (seen) begin
      for (int i = 0; i < nbeats; i++) begin
        burst_data       = base + 32'(i);
        burst_data_valid = 1'b1;
        flush            = (i == flush_at);
        tick();
      end
      burst_data_valid = 1'b0;
      flush            = 1'b0;
      burst_data_done  = 1'b1;
      tick();
      burst_data_done  = 1'b0;
    end
  endtask

  task automatic wait_ack(output bit seen, output logic [31:0] q);
    seen = 1'b0;
    q    = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (core_ack === 1'b1) begin
        seen = 1'b1;
        q    = core_q;
      end else begin
        tick();
      end
    end
    tick();
  endtask

  // Full miss transaction; returns what was observed.
  task automatic miss_fill(input logic [AW-1:0] a, input int nbeats, input logic [31:0] base,
                           input int flush_at, output bit bseen, output logic [AW-1:0] baddr,
                           output bit aseen, output logic [31:0] q);
    issue_rd(a);
    serve(nbeats, base, flush_at, bseen, baddr);
    wait_ack(aseen, q);
  endtask

  task automatic test_reset();
    reset = 1'b1; core_rd = 1'b0; core_addr = '0; flush = 1'b0;
    burst_data = '0; burst_data_valid = 1'b0; burst_data_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++; if (core_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", core_ack); end
    total++; if (core_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", core_busy); end
    total++; if (burst_rd !== 1'b0) begin bad++; $display("FAIL reset_burst_rd got=%b want=0", burst_rd); end
    total++; if (fill_err !== 1'b0) begin bad++; $display("FAIL reset_fill_err got=%b want=0", fill_err); end
    total++; if (core_q !== 32'h0) begin bad++; $display("FAIL reset_core_q got=%h want=0", core_q); end
    total++; if (burst_addr !== 26'h0) begin bad++; $display("FAIL reset_burst_addr got=%h want=0", burst_addr); end
    total++; if (burst_len !== 11'd16) begin bad++; $display("FAIL burst_len got=%0d want=16", burst_len); end
    total++; if (burst_32bit !== 1'b1) begin bad++; $display("FAIL burst_32bit got=%b want=1", burst_32bit); end
  endtask

  task automatic test_cold_miss();
    bit bs, as;
    logic [AW-1:0] ba;
    logic [31:0] q;
    issue_rd(26'h000124);
    total++; if (core_busy !== 1'b1) begin bad++; $display("FAIL miss_busy got=%b want=1", core_busy); end
    serve(8, 32'hA000_0000, -1, bs, ba);
    total++; if (bs !== 1'b1) begin bad++; $display("FAIL miss_burst_rd got=%b want=1", bs); end
    total++; if (ba !== 26'h000120) begin bad++; $display("FAIL miss_burst_addr got=%h want=000120", ba); end
    wait_ack(as, q);
    total++; if (as !== 1'b1) begin bad++; $display("FAIL miss_ack got=%b want=1", as); end
    total++; if (q !== 32'hA000_0001) begin bad++; $display("FAIL miss_q got=%h want=a0000001", q); end
    total++; if (core_busy !== 1'b0) begin bad++; $display("FAIL miss_busy_drop got=%b want=0", core_busy); end
  endtask

  task automatic test_hit();
    int b0;
    b0 = burst_cnt;
    issue_rd(26'h00013C);
    total++; if (core_ack !== 1'b0) begin bad++; $display("FAIL hit_ack_n1 got=%b want=0", core_ack); end
    total++; if (core_busy !== 1'b1) begin bad++; $display("FAIL hit_busy_n1 got=%b want=1", core_busy); end
    tick();
    total++; if (core_ack !== 1'b1) begin bad++; $display("FAIL hit_ack_n2 got=%b want=1", core_ack); end
    total++; if (core_q !== 32'hA000_0007) begin bad++; $display("FAIL hit_q got=%h want=a0000007", core_q); end
    tick();
    total++; if (core_busy !== 1'b0) begin bad++; $display("FAIL hit_busy_n3 got=%b want=0", core_busy); end
    total++; if (burst_cnt !== b0) begin bad++; $display("FAIL hit_no_burst got=%0d want=%0d", burst_cnt, b0); end
  endtask

  // Requests during RESP and during the ack cycle must be dropped.
  task automatic test_drop_busy();
    int b0, a0;
    b0 = burst_cnt;
    a0 = ack_cnt;
    issue_rd(26'h000128);
    core_addr = 26'h001000;
    core_rd   = 1'b1;
    tick();
    total++; if (core_q !== 32'hA000_0002) begin bad++; $display("FAIL drop_q got=%h want=a0000002", core_q); end
    tick();
    core_rd = 1'b0;
    repeat (6) tick();
    total++; if (burst_cnt !== b0) begin bad++; $display("FAIL drop_no_burst got=%0d want=%0d", burst_cnt, b0); end
    total++; if (ack_cnt !== a0 + 1) begin bad++; $display("FAIL drop_ack_count got=%0d want=%0d", ack_cnt, a0 + 1); end
    total++; if (core_busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", core_busy); end
  endtask

  task automatic test_replace();
    bit bs, as;
    logic [AW-1:0] ba;
    logic [31:0] q;
    int b0;
    miss_fill(26'h000400, 8, 32'hB000_0000, -1, bs, ba, as, q);
    total++; if (ba !== 26'h000400) begin bad++; $display("FAIL rep_addr400 got=%h want=000400", ba); end
    total++; if (q !== 32'hB000_0000) begin bad++; $display("FAIL rep_q400 got=%h want=b0000000", q); end
    miss_fill(26'h000800, 8, 32'hC000_0000, -1, bs, ba, as, q);
    total++; if (ba !== 26'h000800) begin bad++; $display("FAIL rep_addr800 got=%h want=000800", ba); end
    total++; if (q !== 32'hC000_0000) begin bad++; $display("FAIL rep_q800 got=%h want=c0000000", q); end
    b0 = burst_cnt;
    issue_rd(26'h000404);
    wait_ack(as, q);
    total++; if (q !== 32'hB000_0001) begin bad++; $display("FAIL rep_hit404_q got=%h want=b0000001", q); end
    total++; if (burst_cnt !== b0) begin bad++; $display("FAIL rep_hit404_burst got=%0d want=%0d", burst_cnt, b0); end
    miss_fill(26'h000120, 8, 32'hA000_0000, -1, bs, ba, as, q);
    total++; if (bs !== 1'b1) begin bad++; $display("FAIL rep_reburst120 got=%b want=1", bs); end
    total++; if (ba !== 26'h000120) begin bad++; $display("FAIL rep_addr120 got=%h want=000120", ba); end
    total++; if (q !== 32'hA000_0000) begin bad++; $display("FAIL rep_q120 got=%h want=a0000000", q); end
  endtask

  task automatic test_flush_mid_fill();
    bit bs, as;
    logic [AW-1:0] ba;
    logic [31:0] q;
    miss_fill(26'h000208, 8, 32'hD000_0000, 3, bs, ba, as, q);
    total++; if (as !== 1'b1) begin bad++; $display("FAIL flush_ack got=%b want=1", as); end
    total++; if (q !== 32'hD000_0002) begin bad++; $display("FAIL flush_q got=%h want=d0000002", q); end
    miss_fill(26'h000208, 8, 32'hD100_0000, -1, bs, ba, as, q);
    total++; if (bs !== 1'b1) begin bad++; $display("FAIL flush_reburst got=%b want=1", bs); end
    total++; if (q !== 32'hD100_0002) begin bad++; $display("FAIL flush_q2 got=%h want=d1000002", q); end
  endtask

  task automatic test_short_burst();
    bit bs, as;
    logic [AW-1:0] ba;
    logic [31:0] q;
    miss_fill(26'h000304, 5, 32'hE000_0000, -1, bs, ba, as, q);
    total++; if (as !== 1'b1) begin bad++; $display("FAIL short_ack got=%b want=1", as); end
    total++; if (fill_err !== 1'b1) begin bad++; $display("FAIL short_fill_err got=%b want=1", fill_err); end
    miss_fill(26'h000304, 8, 32'hE000_0000, -1, bs, ba, as, q);
    total++; if (bs !== 1'b1) begin bad++; $display("FAIL short_reburst got=%b want=1", bs); end
    total++; if (q !== 32'hE000_0001) begin bad++; $display("FAIL short_q got=%h want=e0000001", q); end
    total++; if (fill_err !== 1'b1) begin bad++; $display("FAIL short_sticky got=%b want=1", fill_err); end
  endtask

  task automatic test_reset_mid_fill();
    bit bs, as, seen;
    logic [AW-1:0] ba;
    logic [31:0] q;
    int b0, a0;
    b0 = burst_cnt;
    issue_rd(26'h000304);
    wait_ack(as, q);
    total++; if (q !== 32'hE000_0001) begin bad++; $display("FAIL rmf_prehit_q got=%h want=e0000001", q); end
    total++; if (burst_cnt !== b0) begin bad++; $display("FAIL rmf_prehit_burst got=%0d want=%0d", burst_cnt, b0); end
    issue_rd(26'h000600);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (burst_rd === 1'b1) seen = 1'b1;
      else tick();
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rmf_burst_rd got=%b want=1", seen); end
    a0 = ack_cnt;
    for (int i = 0; i < 3; i++) begin
      burst_data = 32'h5500_0000 + 32'(i); burst_data_valid = 1'b1; tick();
    end
    burst_data_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 3; i < 8; i++) begin
      burst_data = 32'h5500_0000 + 32'(i); burst_data_valid = 1'b1; tick();
    end
    burst_data_valid = 1'b0;
    burst_data_done  = 1'b1;
    tick();
    burst_data_done  = 1'b0;
    repeat (6) tick();
    total++; if (ack_cnt !== a0) begin bad++; $display("FAIL rmf_no_ack got=%0d want=%0d", ack_cnt, a0); end
    total++; if (core_busy !== 1'b0) begin bad++; $display("FAIL rmf_busy got=%b want=0", core_busy); end
    total++; if (fill_err !== 1'b0) begin bad++; $display("FAIL rmf_fill_err got=%b want=0", fill_err); end
    miss_fill(26'h000304, 8, 32'hF000_0000, -1, bs, ba, as, q);
    total++; if (bs !== 1'b1) begin bad++; $display("FAIL rmf_reburst got=%b want=1", bs); end
    total++; if (ba !== 26'h000300) begin bad++; $display("FAIL rmf_addr got=%h want=000300", ba); end
    total++; if (q !== 32'hF000_0001) begin bad++; $display("FAIL rmf_q got=%h want=f0000001", q); end
  endtask

  // Flush coinciding with a request that would hit: the request must miss.
  task automatic test_flush_with_rd();
    bit bs, as;
    logic [AW-1:0] ba;
    logic [31:0] q;
    flush = 1'b1;
    issue_rd(26'h000304);
    flush = 1'b0;
    serve(8, 32'h1234_0000, -1, bs, ba);
    total++; if (bs !== 1'b1) begin bad++; $display("FAIL fwr_burst got=%b want=1", bs); end
    wait_ack(as, q);
    total++; if (q !== 32'h1234_0001) begin bad++; $display("FAIL fwr_q got=%h want=12340001", q); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_drop_busy();
    test_replace();
    test_flush_mid_fill();
    test_short_burst();
    test_reset_mid_fill();
    test_flush_with_rd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
